// File: rtl/ama_riscv_alu_arb.sv
// Two requesters share one combinational ALU through a round-robin arbiter and a
// single registered response slot. Define ALU_ARB_PERF_EN to add grant/stall counters.
package ama_riscv_pkg;
  localparam int ARCH_WIDTH = 32;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_OP_ADD    = 4'd0;
  localparam alu_op_t ALU_OP_SUB    = 4'd1;
  localparam alu_op_t ALU_OP_SLL    = 4'd2;
  localparam alu_op_t ALU_OP_SLT    = 4'd3;
  localparam alu_op_t ALU_OP_SLTU   = 4'd4;
  localparam alu_op_t ALU_OP_XOR    = 4'd5;
  localparam alu_op_t ALU_OP_SRL    = 4'd6;
  localparam alu_op_t ALU_OP_SRA    = 4'd7;
  localparam alu_op_t ALU_OP_OR     = 4'd8;
  localparam alu_op_t ALU_OP_AND    = 4'd9;
  localparam alu_op_t ALU_OP_PASS_B = 4'd10;
endpackage

module ama_riscv_alu
  import ama_riscv_pkg::*;
(
  input  alu_op_t                 op_i,
  input  logic [ARCH_WIDTH-1:0]   a_i,
  input  logic [ARCH_WIDTH-1:0]   b_i,
  output logic [ARCH_WIDTH-1:0]   res_o
);
  logic signed [ARCH_WIDTH-1:0] a_s;
  logic signed [ARCH_WIDTH-1:0] b_s;
  logic [4:0]                   shamt;

  assign a_s   = a_i;
  assign b_s   = b_i;
  assign shamt = b_i[4:0];

  always_comb begin
    res_o = '0;
    case (op_i)
      ALU_OP_ADD:    res_o = a_i + b_i;
      ALU_OP_SUB:    res_o = a_i - b_i;
      ALU_OP_SLL:    res_o = a_i << shamt;
      ALU_OP_SLT:    res_o = {{(ARCH_WIDTH-1){1'b0}}, (a_s < b_s)};
      ALU_OP_SLTU:   res_o = {{(ARCH_WIDTH-1){1'b0}}, (a_i < b_i)};
      ALU_OP_XOR:    res_o = a_i ^ b_i;
      ALU_OP_SRL:    res_o = a_i >> shamt;
      ALU_OP_SRA:    res_o = a_s >>> shamt;
      ALU_OP_OR:     res_o = a_i | b_i;
      ALU_OP_AND:    res_o = a_i & b_i;
      ALU_OP_PASS_B: res_o = b_i;
      default:       res_o = '0;
    endcase
  end
endmodule

module ama_riscv_alu_arb
  import ama_riscv_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  alu_op_t               req0_op,
  input  logic [ARCH_WIDTH-1:0] req0_a,
  input  logic [ARCH_WIDTH-1:0] req0_b,
  input  logic [TAG_W-1:0]      req0_tag,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  alu_op_t               req1_op,
  input  logic [ARCH_WIDTH-1:0] req1_a,
  input  logic [ARCH_WIDTH-1:0] req1_b,
  input  logic [TAG_W-1:0]      req1_tag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic [ARCH_WIDTH-1:0] rsp_data
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]           perf_grant0,
  output logic [31:0]           perf_grant1,
  output logic [31:0]           perf_stall
`endif
);
  logic                  rsp_valid_q;
  logic                  rsp_id_q;
  logic [TAG_W-1:0]      rsp_tag_q;
  logic [ARCH_WIDTH-1:0] rsp_data_q;
  logic                  last_grant_q;

  logic                  slot_free;
  logic                  gnt0;
  logic                  gnt1;
  logic                  any_gnt;
  alu_op_t               alu_op;
  logic [ARCH_WIDTH-1:0] alu_a;
  logic [ARCH_WIDTH-1:0] alu_b;
  logic [ARCH_WIDTH-1:0] alu_res;
  logic [TAG_W-1:0]      rsp_tag_d;

  // The slot can take a new result in the same cycle its current one drains.
  assign slot_free = !rsp_valid_q || rsp_ready;
  assign gnt0      = slot_free && req0_valid && (!req1_valid || last_grant_q);
  assign gnt1      = slot_free && req1_valid && (!req0_valid || !last_grant_q);
  assign any_gnt   = gnt0 || gnt1;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // AND-OR mux on one-hot grants: with no grant the ALU sees ADD 0,0 and stays quiet.
  assign alu_op    = ({4{gnt0}} & req0_op) | ({4{gnt1}} & req1_op);
  assign alu_a     = ({ARCH_WIDTH{gnt0}} & req0_a) | ({ARCH_WIDTH{gnt1}} & req1_a);
  assign alu_b     = ({ARCH_WIDTH{gnt0}} & req0_b) | ({ARCH_WIDTH{gnt1}} & req1_b);
  assign rsp_tag_d = ({TAG_W{gnt0}} & req0_tag) | ({TAG_W{gnt1}} & req1_tag);

  ama_riscv_alu u_alu (
    .op_i  (alu_op),
    .a_i   (alu_a),
    .b_i   (alu_b),
    .res_o (alu_res)
  );

  // Response slot: grant cycle N -> visible in cycle N+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_data_q   <= '0;
      last_grant_q <= 1'b1;
    end else if (any_gnt) begin
      rsp_valid_q  <= 1'b1;
      rsp_id_q     <= gnt1;
      rsp_tag_q    <= rsp_tag_d;
      rsp_data_q   <= alu_res;
      last_grant_q <= gnt1;
    end else if (rsp_ready) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_data  = rsp_data_q;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_grant0_q;
  logic [31:0] perf_grant1_q;
  logic [31:0] perf_stall_q;
  logic [1:0]  stall_inc;

  // Each waiting requester counts separately, so a fully blocked cycle adds two.
  assign stall_inc = {1'b0, (req0_valid && !gnt0)} + {1'b0, (req1_valid && !gnt1)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant0_q <= '0;
      perf_grant1_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (gnt0) perf_grant0_q <= perf_grant0_q + 32'd1;
      if (gnt1) perf_grant1_q <= perf_grant1_q + 32'd1;
      perf_stall_q <= perf_stall_q + {30'd0, stall_inc};
    end
  end

  assign perf_grant0 = perf_grant0_q;
  assign perf_grant1 = perf_grant1_q;
  assign perf_stall  = perf_stall_q;
`endif
endmodule
